ub_readback: RTL and testbench

Result readback engine for the TPU: after a run, streams a block of result words out of the unified buffer to the host as a framed byte stream over a valid/ready interface. It is the outbound counterpart of the host-to-TPU load path. It sits between the unified buffer's read port and the host link, and is kicked by a one-cycle `start` pulse from the top level.

---
 rtl/tpu_readback_pkg.sv | 21 ++
 rtl/readback_serializer.sv | 50 +++++
 rtl/ub_readback.sv | 151 +++++++++++++++
 tb/tb_ub_readback.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/tpu_readback_pkg.sv
// Shared types and constants for the unified-buffer readback path.
// ST_CSUM exists only when READBACK_CHECKSUM_EN is defined.
package tpu_readback_pkg;

  localparam logic [7:0] RB_SYNC_BYTE = 8'hA5;

`ifdef READBACK_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_HDR, ST_LEN, ST_FETCH, ST_WAIT, ST_SEND, ST_CSUM, ST_DONE
  } rb_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_HDR, ST_LEN, ST_FETCH, ST_WAIT, ST_SEND, ST_DONE
  } rb_state_t;
`endif

  function automatic int RB_BYTES_PER_WORD(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/readback_serializer.sv
// Parallel-load shift register that emits bytes LSB-first over valid/ready.
// A single framing byte is loaded zero-extended with a count of one.
module readback_serializer
  import tpu_readback_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              load_word,
  input  logic [DATA_W-1:0] load_data,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  output logic              last_accepted
);

  localparam int BPW   = RB_BYTES_PER_WORD(DATA_W);
  localparam int CNT_W = $clog2(BPW + 1);

  logic [DATA_W-1:0] shift_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              valid_reg;
  logic              accept;

  assign accept        = valid_reg && tx_ready;
  assign last_accepted = accept && (cnt_reg == CNT_W'(1));
  assign tx_data       = shift_reg[7:0];
  assign tx_valid      = valid_reg;

  // A load always wins over an acceptance in the same cycle, so the FSM can
  // queue the next byte on the edge that retires the current one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (load) begin
      shift_reg <= load_data;
      cnt_reg   <= load_word ? CNT_W'(BPW) : CNT_W'(1);
      valid_reg <= 1'b1;
    end else if (accept) begin
      shift_reg <= shift_reg >> 8;
      cnt_reg   <= cnt_reg - CNT_W'(1);
      if (cnt_reg == CNT_W'(1)) valid_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/ub_readback.sv
// Streams a block of unified-buffer words to the host as a framed byte stream.
// Define READBACK_CHECKSUM_EN to append an XOR checksum of the payload bytes.
module ub_readback
  import tpu_readback_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int LEN_W = ADDR_W + 1;

  rb_state_t         state_reg, state_next;
  logic [ADDR_W-1:0] base_reg;
  logic [ADDR_W-1:0] mem_rd_addr_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  idx_reg;
  logic              busy_reg, done_reg, mem_rd_en_reg;
  logic              ser_load, ser_load_word, last_accepted;
  logic [DATA_W-1:0] ser_load_data;

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign mem_rd_en   = mem_rd_en_reg;
  assign mem_rd_addr = mem_rd_addr_reg;

`ifdef READBACK_CHECKSUM_EN
  logic [7:0] csum_reg, csum_next;

  // Folds in the payload byte retiring this cycle so the final word's last
  // byte is included when CSUM is loaded on the same edge.
  assign csum_next = (state_reg == ST_SEND && tx_valid && tx_ready) ?
                     (csum_reg ^ tx_data) : csum_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          csum_reg <= '0;
    else if (state_reg == ST_IDLE && start) csum_reg <= '0;
    else                                 csum_reg <= csum_next;
  end
`endif

  always_comb begin
    state_next    = state_reg;
    ser_load      = 1'b0;
    ser_load_word = 1'b0;
    ser_load_data = '0;
    case (state_reg)
      ST_IDLE: if (start) begin
        state_next    = ST_HDR;
        ser_load      = 1'b1;
        ser_load_data = DATA_W'(RB_SYNC_BYTE);
      end
      ST_HDR: if (last_accepted) begin
        state_next    = ST_LEN;
        ser_load      = 1'b1;
        ser_load_data = DATA_W'(8'(len_reg));
      end
      ST_LEN: if (last_accepted) begin
        if (len_reg != '0) begin
          state_next = ST_FETCH;
        end else begin
`ifdef READBACK_CHECKSUM_EN
          state_next    = ST_CSUM;
          ser_load      = 1'b1;
          ser_load_data = DATA_W'(csum_reg);
`else
          state_next = ST_DONE;
`endif
        end
      end
      ST_FETCH: state_next = ST_WAIT;
      ST_WAIT: begin
        state_next    = ST_SEND;
        ser_load      = 1'b1;
        ser_load_word = 1'b1;
        ser_load_data = mem_rd_data;
      end
      ST_SEND: if (last_accepted) begin
        if (idx_reg != len_reg) begin
          state_next = ST_FETCH;
        end else begin
`ifdef READBACK_CHECKSUM_EN
          state_next    = ST_CSUM;
          ser_load      = 1'b1;
          ser_load_data = DATA_W'(csum_next);
`else
          state_next = ST_DONE;
`endif
        end
      end
`ifdef READBACK_CHECKSUM_EN
      ST_CSUM: if (last_accepted) state_next = ST_DONE;
`endif
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= ST_IDLE;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      mem_rd_en_reg   <= 1'b0;
      mem_rd_addr_reg <= '0;
      base_reg        <= '0;
      len_reg         <= '0;
      idx_reg         <= '0;
    end else begin
      state_reg     <= state_next;
      busy_reg      <= (state_next != ST_IDLE) && (state_next != ST_DONE);
      done_reg      <= (state_next == ST_DONE);
      mem_rd_en_reg <= (state_next == ST_FETCH);
      if (state_reg == ST_IDLE && start) begin
        base_reg <= base_addr;
        len_reg  <= length;
        idx_reg  <= '0;
      end
      // Address arithmetic truncates to ADDR_W, so reads wrap past the top.
      if (state_next == ST_FETCH) mem_rd_addr_reg <= base_reg + idx_reg[ADDR_W-1:0];
      if (state_reg == ST_FETCH)  idx_reg <= idx_reg + LEN_W'(1);
    end
  end

  readback_serializer #(.DATA_W(DATA_W)) u_ser (
    .clk           (clk),
    .reset         (reset),
    .load          (ser_load),
    .load_word     (ser_load_word),
    .load_data     (ser_load_data),
    .tx_ready      (tx_ready),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .last_accepted (last_accepted)
  );

endmodule

// File: tb/tb_ub_readback.sv
// Directed bench for ub_readback: table of frames plus back-pressure,
// ignored re-start and mid-frame reset sequences.
module tb_ub_readback;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  base_addr = '0;
  logic [6:0]  length = '0;
  logic        busy, done, mem_rd_en;
  logic [5:0]  mem_rd_addr;
  logic [15:0] mem_rd_data = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;

  int n_cmp = 0;
  int n_fail = 0;

`ifdef READBACK_CHECKSUM_EN
  localparam int CS_EXTRA = 1;
`else
  localparam int CS_EXTRA = 0;
`endif

  ub_readback #(.DATA_W(16), .ADDR_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:63];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  typedef struct packed {
    logic [5:0]      base;
    logic [6:0]      len;
    logic [15:0]     w0;
    logic [15:0]     w1;
    logic [5:0]      a0;
    logic [5:0]      a1;
    int              nbytes;
    logic [0:5][7:0] b;
    int              done_cyc;
  } vec_t;

  vec_t vecs [4];

  logic [7:0] byte_q[$];
  int         byte_cyc_q[$];
  int         rd_cyc_q[$];
  logic [5:0] rd_addr_q[$];
  int         done_cyc;
  logic       busy_c1, busy_dn;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rd_en"}, mem_rd_en, 0);
    check({tag, "_rd_addr"}, mem_rd_addr, 0);
    check({tag, "_tx_valid"}, tx_valid, 0);
    check({tag, "_tx_data"}, tx_data, 0);
  endtask

  task automatic run_frame(input logic [5:0] b, input logic [6:0] l,
                           input int stall_at, input int repulse_at, input int reset_at);
    logic [7:0] held = '0;
    byte_q.delete(); byte_cyc_q.delete(); rd_cyc_q.delete(); rd_addr_q.delete();
    done_cyc = -1; busy_c1 = 1'b0; busy_dn = 1'b1;
    @(negedge clk);
    start = 1'b1; base_addr = b; length = l;
    @(posedge clk);
    #1 start = 1'b0; base_addr = 6'd33; length = 7'd7;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == repulse_at) begin
        start = 1'b1; base_addr = 6'd20; length = 7'd5;
      end else if (k == repulse_at + 1) begin
        start = 1'b0;
      end
      if (stall_at > 0 && k == stall_at) begin
        held = tx_data;
        check("stall_first_byte", tx_data, 8'h34);
      end
      if (stall_at > 0 && k > stall_at && k <= stall_at + 5) begin
        check($sformatf("hold_valid_c%0d", k), tx_valid, 1);
        check($sformatf("hold_data_c%0d", k), tx_data, held);
      end
      tx_ready = !(stall_at > 0 && k >= stall_at && k < stall_at + 5);
      if (k == reset_at) begin
        reset = 1'b0;
        #1 check_idle_outputs("midreset");
        @(negedge clk);
        check_idle_outputs("midreset_held");
        reset = 1'b1;
        return;
      end
      if (k == 1) busy_c1 = busy;
      if (tx_valid && tx_ready) begin
        byte_q.push_back(tx_data);
        byte_cyc_q.push_back(k);
      end
      if (mem_rd_en) begin
        rd_cyc_q.push_back(k);
        rd_addr_q.push_back(mem_rd_addr);
      end
      if (done) begin
        done_cyc = k;
        busy_dn = busy;
        break;
      end
    end
    if (done_cyc < 0) check("done_timeout", 0, 1);
    @(negedge clk);
    check("post_done_pulse", done, 0);
    check("post_tx_valid", tx_valid, 0);
  endtask

  task automatic check_frame(input vec_t v, input int done_exp, input bit check_cycles);
    int         exp_n = v.nbytes + CS_EXTRA;
    logic [7:0] xs = '0;
    for (int i = 2; i < v.nbytes; i++) xs ^= v.b[i];
    check("byte_count", byte_q.size(), exp_n);
    for (int i = 0; i < v.nbytes && i < byte_q.size(); i++) begin
      check($sformatf("byte%0d", i), byte_q[i], v.b[i]);
      if (check_cycles)
        check($sformatf("byte%0d_cycle", i), byte_cyc_q[i],
              (i < 2) ? i + 1 : 5 + 4 * ((i - 2) / 2) + ((i - 2) % 2));
    end
    if (CS_EXTRA == 1 && byte_q.size() == exp_n) check("csum", byte_q[exp_n-1], xs);
    check("read_count", rd_cyc_q.size(), v.len);
    for (int w = 0; w < rd_cyc_q.size() && w < v.len; w++) begin
      check($sformatf("rd%0d_addr", w), rd_addr_q[w], (w == 0) ? v.a0 : v.a1);
      if (check_cycles) check($sformatf("rd%0d_cycle", w), rd_cyc_q[w], 3 + 4 * w);
    end
    check("done_cycle", done_cyc, done_exp);
    check("busy_c1", busy_c1, 1);
    check("busy_at_done", busy_dn, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{6'd4,  7'd2, 16'h1234, 16'hBEEF, 6'd4,  6'd5, 6,
                {8'hA5, 8'h02, 8'h34, 8'h12, 8'hEF, 8'hBE}, 11};
    vecs[1] = '{6'd9,  7'd0, 16'h0000, 16'h0000, 6'd9,  6'd10, 2,
                {8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3};
    vecs[2] = '{6'd63, 7'd2, 16'hCAFE, 16'h0102, 6'd63, 6'd0, 6,
                {8'hA5, 8'h02, 8'hFE, 8'hCA, 8'h02, 8'h01}, 11};
    vecs[3] = '{6'd10, 7'd1, 16'h00FF, 16'h0000, 6'd10, 6'd11, 4,
                {8'hA5, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h00}, 7};
    for (int i = 0; i < 64; i++) mem[i] = 16'h5A00 + 16'(i);

    repeat (3) @(negedge clk);
    check_idle_outputs("in_reset");
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("after_reset");

    for (int i = 0; i < 4; i++) begin
      if (vecs[i].len != 0) begin
        mem[vecs[i].a0] = vecs[i].w0;
        mem[vecs[i].a1] = vecs[i].w1;
      end
      run_frame(vecs[i].base, vecs[i].len, 0, 0, 0);
      check_frame(vecs[i], vecs[i].done_cyc + CS_EXTRA, 1'b1);
      $display("frame %0d: base=%0d len=%0d bytes=%0d done@%0d", i,
               vecs[i].base, vecs[i].len, byte_q.size(), done_cyc);
    end

    // Back-pressure: five stalled cycles on the first payload byte.
    mem[4] = 16'h1234; mem[5] = 16'hBEEF;
    run_frame(6'd4, 7'd2, 5, 0, 0);
    check_frame(vecs[0], 16 + CS_EXTRA, 1'b0);
    check("stall_byte_cycle", (byte_cyc_q.size() > 2) ? byte_cyc_q[2] : -1, 10);
    $display("stall frame: bytes=%0d done@%0d", byte_q.size(), done_cyc);

    // A start pulse mid-frame must not disturb the frame in flight.
    run_frame(6'd4, 7'd2, 0, 4, 0);
    check_frame(vecs[0], 11 + CS_EXTRA, 1'b1);
    repeat (4) @(negedge clk);
    check("repulse_no_restart", busy, 0);
    $display("repulse frame: bytes=%0d done@%0d", byte_q.size(), done_cyc);

    // Reset during SEND aborts; the next frame starts clean.
    run_frame(6'd4, 7'd2, 0, 0, 5);
    $display("reset frame: aborted after %0d bytes", byte_q.size());
    @(negedge clk);
    check_idle_outputs("post_abort");
    mem[10] = 16'h00FF;
    run_frame(6'd10, 7'd1, 0, 0, 0);
    check_frame(vecs[3], 7 + CS_EXTRA, 1'b1);
    $display("fresh frame: first=0x%0h bytes=%0d done@%0d",
             (byte_q.size() > 0) ? byte_q[0] : 8'h00, byte_q.size(), done_cyc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
